// File: rtl/painel_scan_controller_if.sv
// Control and display-drive bundle of the panel scan controller: run/clear in, row drive and scroll state out.
// The master modport is the controller side; the slave side drives run/clear and consumes the drive signals.
interface painel_scan_controller_if #(
  parameter int ROWS    = 7,
  parameter int MSG_LEN = 16
);
  localparam int OFF_W = $clog2(MSG_LEN);

  logic             run;
  logic             clear;
  logic [ROWS-1:0]  row_sel;
  logic [2:0]       row_idx;
  logic             blank;
  logic             tick_row;
  logic             tick_frame;
  logic             tick_scroll;
  logic [OFF_W-1:0] offset;

  modport master (
    input  run, clear,
    output row_sel, row_idx, blank, tick_row, tick_frame, tick_scroll, offset
  );

  modport slave (
    output run, clear,
    input  row_sel, row_idx, blank, tick_row, tick_frame, tick_scroll, offset
  );
endinterface

// File: rtl/painel_scan_controller.sv
// LED-matrix row scan with blank window plus run-gated scroll offset; outputs decoded from registers,
// row/offset update one edge after their tick; no backpressure (free-running scan, run only gates scrolling).
module painel_scan_controller #(
  parameter int SCAN_DIV     = 65536,
  parameter int BLANK_CYC    = 4,
  parameter int ROWS         = 7,
  parameter int SCROLL_TICKS = 256,
  parameter int MSG_LEN      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  painel_scan_controller_if.master bus
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int SCR_W = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam int OFF_W = $clog2(MSG_LEN);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);
  localparam logic [2:0]       ROW_LAST   = 3'(ROWS - 1);
  localparam logic [SCR_W-1:0] SCR_LAST   = SCR_W'(SCROLL_TICKS - 1);
  localparam logic [OFF_W-1:0] OFF_LAST   = OFF_W'(MSG_LEN - 1);
  localparam logic [ROWS-1:0]  ROW0       = ROWS'(1);

  typedef enum logic {ST_BLANK, ST_DRIVE} slot_state_e;

  slot_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       row_idx_q, row_idx_d;
  logic [SCR_W-1:0] scr_cnt_q, scr_cnt_d;
  logic [OFF_W-1:0] offset_q, offset_d;

  logic             slot_end;
  logic             blank;
  logic [ROWS-1:0]  row_sel;
  logic             tick_scroll;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      div_cnt_q <= '0;
      row_idx_q <= '0;
      scr_cnt_q <= '0;
      offset_q  <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      row_idx_q <= row_idx_d;
      scr_cnt_q <= scr_cnt_d;
      offset_q  <= offset_d;
    end
  end

  assign slot_end = (div_cnt_q == DIV_LAST);

  // Slot FSM: the state mirrors div_cnt < BLANK_CYC, so row_sel never leaves a flop-driven decode.
  always_comb begin
    state_d = state_q;
    blank   = 1'b0;
    row_sel = '0;
    case (state_q)
      ST_BLANK: begin
        blank = 1'b1;
        if (div_cnt_q == BLANK_LAST) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        row_sel = ROW0 << row_idx_q;
        if (slot_end) state_d = ST_BLANK;
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    div_cnt_d   = div_cnt_q + 1'b1;
    row_idx_d   = row_idx_q;
    scr_cnt_d   = scr_cnt_q;
    offset_d    = offset_q;
    tick_scroll = 1'b0;

    if (slot_end) begin
      div_cnt_d = '0;
      row_idx_d = (row_idx_q == ROW_LAST) ? 3'd0 : row_idx_q + 3'd1;
    end

    // clear wins over a same-cycle advance and also swallows that cycle's scroll tick.
    if (bus.clear) begin
      scr_cnt_d = '0;
      offset_d  = '0;
    end else if (slot_end && bus.run) begin
      if (scr_cnt_q == SCR_LAST) begin
        tick_scroll = 1'b1;
        scr_cnt_d   = '0;
        offset_d    = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
      end else begin
        scr_cnt_d = scr_cnt_q + 1'b1;
      end
    end
  end

  assign bus.row_sel     = row_sel;
  assign bus.row_idx     = row_idx_q;
  assign bus.blank       = blank;
  assign bus.tick_row    = slot_end;
  assign bus.tick_frame  = slot_end && (row_idx_q == ROW_LAST);
  assign bus.tick_scroll = tick_scroll;
  assign bus.offset      = offset_q;
endmodule

// File: tb/tb_painel_scan_controller.sv
// Randomized scoreboard bench for painel_scan_controller plus a small corner-configuration instance.
module tb_painel_scan_controller;
  localparam int SD = 8, BC = 2, NR = 7, ST = 3, ML = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  painel_scan_controller_if #(.ROWS(NR), .MSG_LEN(ML)) bus ();
  painel_scan_controller_if #(.ROWS(2),  .MSG_LEN(4))  bus2 ();

  painel_scan_controller #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ROWS(NR),
                           .SCROLL_TICKS(ST), .MSG_LEN(ML))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  painel_scan_controller #(.SCAN_DIV(2), .BLANK_CYC(1), .ROWS(2),
                           .SCROLL_TICKS(1), .MSG_LEN(4))
    dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

  typedef struct {
    int blank, row_sel, row_idx, tick_row, tick_frame, tick_scroll, offset;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  bit corner_done = 1'b0;

  // Reference state: cycles since reset, row ticks counted toward the next scroll, offset.
  int m_t = 0, m_acc = 0, m_off = 0;
  int n_t = 0, n_acc = 0, n_off = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: builds the expected outputs for the current cycle, then the state after the next edge.
  initial begin
    exp_t e;
    int pos, row;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        e = '{1, 0, 0, 0, 0, 0, 0};
        n_t = 0; n_acc = 0; n_off = 0;
      end else begin
        pos = m_t % SD;
        row = (m_t / SD) % NR;
        e.blank       = (pos < BC) ? 1 : 0;
        e.row_sel     = (pos < BC) ? 0 : (1 << row);
        e.row_idx     = row;
        e.tick_row    = (pos == SD - 1) ? 1 : 0;
        e.tick_frame  = (e.tick_row == 1 && row == NR - 1) ? 1 : 0;
        e.tick_scroll = (e.tick_row == 1 && bus.run && !bus.clear && m_acc == ST - 1) ? 1 : 0;
        e.offset      = m_off;
        n_t = m_t + 1; n_acc = m_acc; n_off = m_off;
        if (bus.clear) begin
          n_acc = 0; n_off = 0;
        end else if (e.tick_row == 1 && bus.run) begin
          n_acc = m_acc + 1;
          if (n_acc == ST) begin
            n_acc = 0;
            n_off = (m_off + 1) % ML;
          end
        end
      end
      exp_q.push_back(e);
      @(posedge clk);
      if (!rst_n) begin
        m_t = 0; m_acc = 0; m_off = 0;
      end else begin
        m_t = n_t; m_acc = n_acc; m_off = n_off;
      end
    end
  end

  // Monitor: every cycle presents a full output word, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("blank",       32'(bus.blank),       e.blank);
        chk("row_sel",     32'(bus.row_sel),     e.row_sel);
        chk("row_idx",     32'(bus.row_idx),     e.row_idx);
        chk("tick_row",    32'(bus.tick_row),    e.tick_row);
        chk("tick_frame",  32'(bus.tick_frame),  e.tick_frame);
        chk("tick_scroll", 32'(bus.tick_scroll), e.tick_scroll);
        chk("offset",      32'(bus.offset),      e.offset);
      end
    end
  end

  // Corner configuration: 2-cycle slots, 1 blank cycle, 2 rows, scroll on every row tick.
  initial begin
    int pos, slot;
    bus2.run = 1'b1;
    bus2.clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst2_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #3;
      pos = k % 2;
      slot = k / 2;
      chk("corner_row_sel", 32'(bus2.row_sel), (pos == 0) ? 0 : ((slot % 2 == 0) ? 1 : 2));
      chk("corner_tick_scroll", 32'(bus2.tick_scroll), (pos == 1) ? 1 : 0);
      chk("corner_offset", 32'(bus2.offset), slot % 4);
      chk("corner_onehot", ($countones(bus2.row_sel) <= 1) ? 32'd1 : 32'd0, 1);
    end
    corner_done = 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit found;
    bus.run = 1'b0;
    bus.clear = 1'b0;
    cyc(3);
    rst_n = 1'b1;

    // Reset release and scan timing with run low; cycle 0 is the first cycle after release.
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #2;
      if (c == 0 || c == 1) chk("rel_blank", 32'(bus.blank), 1);
      if (c == 2) chk("rel_row_sel_c2", 32'(bus.row_sel), 1);
      if (c == 7) chk("rel_tick_row_c7", 32'(bus.tick_row), 1);
      if (c == 8) chk("rel_row_idx_c8", 32'(bus.row_idx), 1);
      if (c == 8) chk("rel_row_sel_c8", 32'(bus.row_sel), 0);
      if (c == 55) chk("rel_tick_frame_c55", 32'(bus.tick_frame), 1);
      if (c == 56) chk("rel_row_idx_c56", 32'(bus.row_idx), 0);
    end
    cyc(1);

    // Free-running scroll.
    bus.run = 1'b1;
    cyc(100);

    // Run gating: clear, wait for the first step, hold run low for 10 slots.
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc(1);
      if (m_off == 1) found = 1'b1;
    end
    chk("gate_reached_offset1", 32'(found), 1);
    bus.run = 1'b0;
    cyc(10 * SD);
    @(negedge clk);
    #2;
    chk("gate_offset_held", 32'(bus.offset), 1);
    @(posedge clk);
    #1;
    bus.run = 1'b1;
    cyc(40);

    // Clear on the exact scroll-tick cycle while offset is 2.
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (m_off == 2 && m_acc == ST - 1 && (m_t % SD) == SD - 1) found = 1'b1;
      else cyc(1);
    end
    chk("clr_found", 32'(found), 1);
    bus.clear = 1'b1;
    @(negedge clk);
    #2;
    chk("clr_tick_scroll_suppressed", 32'(bus.tick_scroll), 0);
    chk("clr_tick_row_kept", 32'(bus.tick_row), 1);
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    @(negedge clk);
    #2;
    chk("clr_offset_zero", 32'(bus.offset), 0);
    chk("clr_row_advanced", 32'(bus.blank), 1);
    cyc(1);
    cyc(60);

    // Random run toggling and clear pulses.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
      bus.clear = ($urandom_range(0, 49) == 0);
      cyc(1);
    end
    bus.clear = 1'b0;
    bus.run = 1'b1;

    // Asynchronous reset at div_cnt=5 of row 3 with offset 2.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cyc(1);
      if (m_off == 2 && (m_t % SD) == 5 && ((m_t / SD) % NR) == 3) found = 1'b1;
    end
    chk("arst_found", 32'(found), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_blank", 32'(bus.blank), 1);
    chk("arst_row_sel", 32'(bus.row_sel), 0);
    chk("arst_row_idx", 32'(bus.row_idx), 0);
    chk("arst_offset", 32'(bus.offset), 0);
    chk("arst_ticks", {29'd0, bus.tick_row, bus.tick_frame, bus.tick_scroll}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(80);

    for (int i = 0; i < 200 && !corner_done; i++) cyc(1);
    chk("corner_finished", 32'(corner_done), 1);
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/painel_scan_controller.md
# painel_scan_controller

Synchronous scan and scroll sequencer for the digital electronic panel's LED matrix. Replaces ripple-clocked timing with single-clock enables. It time-multiplexes the matrix rows with an anti-ghosting blank window and advances the message scroll offset at a slower, run-gated rate. Sits between the system clock and the panel's row drivers and column-data (message ROM) addressing.

## Interface
- SCAN_DIV, 65536: clk cycles per row slot; ≥ 2.
- BLANK_CYC, 4: blanked cycles at the start of each row slot; 1 ≤ BLANK_CYC < SCAN_DIV.
- ROWS, 7: matrix rows; 2..8.
- SCROLL_TICKS, 256: row ticks per scroll step; ≥ 1.
- MSG_LEN, 16: message length in columns; ≥ 2. Scroll offset wraps at this value.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 enables scrolling. Scanning never stops.
- clear  in  1  synchronous one-cycle pulse; zeroes the scroll offset and the scroll prescaler.
- row_sel  out  ROWS  one-hot row drive, active-high; all-zero while blanked.
- row_idx  out  3  index of the current row, 0..ROWS-1.
- blank  out  1  1 during the blank window of each slot.
- tick_row  out  1  one-cycle pulse on the last cycle of each row slot.
- tick_frame  out  1  one-cycle pulse on the last cycle of row ROWS-1.
- tick_scroll  out  1  one-cycle pulse on the cycle the offset advances.
- offset  out  clog2(MSG_LEN)  current scroll offset, i.e. the message column shown in display column 0.

## Operation
- Registers:
  - div_cnt (0..SCAN_DIV-1)
  - row_idx
  - scr_cnt (0..SCROLL_TICKS-1)
  - offset
- Row-slot FSM, two states:
  - BLANK: div_cnt < BLANK_CYC. blank=1, row_sel=0.
  - DRIVE: otherwise. blank=0, row_sel = 1<<row_idx.
  - BLANK→DRIVE when div_cnt reaches BLANK_CYC.
  - DRIVE→BLANK on slot end.
- Slot end occurs when div_cnt == SCAN_DIV-1:
  - tick_row=1.
  - Next edge: div_cnt←0 and row_idx←row_idx+1, wrapping ROWS-1→0.
- tick_frame = tick_row && row_idx == ROWS-1.
- Scroll prescaler advances only on tick_row && run:
  - If scr_cnt == SCROLL_TICKS-1: tick_scroll=1. Next edge: scr_cnt←0 and offset←offset+1, wrapping MSG_LEN-1→0.
  - Else scr_cnt←scr_cnt+1.
  - With run=0, scr_cnt and offset hold.
- clear has priority over any same-cycle advance:
  - scr_cnt←0 and offset←0.
  - tick_scroll is suppressed that cycle.
  - Scan counters are unaffected.
- run is sampled only when tick_row=1; toggling run mid-slot has no effect until slot end.
- All ticks and row_sel/blank are decoded from registered state, with no input-to-output combinational path except:
  - tick_scroll depends on run and clear in the same cycle.

## Timing
- Reset (async assert, any time):
  - div_cnt=0, row_idx=0, scr_cnt=0, offset=0.
  - Outputs: blank=1, row_sel=0, all ticks 0.
- Reset release: the first rising edge after rst_n=1 increments div_cnt to 1.
- Reset mid-slot or mid-scroll aborts immediately. There is no completion of the partial slot.
- Row period is exactly SCAN_DIV cycles. Per slot: BLANK_CYC cycles blank, SCAN_DIV-BLANK_CYC cycles driven.
- Frame period is ROWS×SCAN_DIV cycles.
- Scroll period with run held at 1 is SCROLL_TICKS×SCAN_DIV cycles.
- Latencies:
  - offset and row_idx change on the edge after their tick.
  - row_sel shows the new row only after the new slot's blank window, so there is never overlap between two rows.
- Duty: row_sel is never multi-hot. Between consecutive rows there are at least BLANK_CYC all-zero cycles.

## Test plan
Parameters: SCAN_DIV=8, BLANK_CYC=2, ROWS=7, SCROLL_TICKS=3, MSG_LEN=4 unless stated.
- Reset/scan: release rst_n, run=0. Required response:
  - blank=1 for cycles 0-1; row_sel=0000001 for cycles 2-7.
  - tick_row at cycle 7; row_idx=1 at cycle 8.
  - tick_frame at cycle 55; row_idx back to 0 at cycle 56.
- Scroll: run=1. Required response:
  - tick_scroll coincides with every 3rd tick_row (cycles 23, 47, 71, 95).
  - offset goes 1, 2, 3, 0.
- Run gating: drop run after the first scroll and hold it low for 10 slots, then raise it. Required response:
  - offset stays 1 while run is low.
  - The next tick_scroll comes 3 tick_rows after run returns high.
- Clear priority: assert clear on the exact cycle of tick_scroll with offset=2. Required response:
  - offset=0 and scr_cnt=0 next cycle.
  - tick_scroll=0.
  - row scan timing unchanged.
- Async reset mid-slot: pull rst_n low at div_cnt=5 of row 3 with offset=2. Required response:
  - Immediately blank=1, row_sel=0, row_idx=0, offset=0, no tick pulses.
- Corner: SCAN_DIV=2, BLANK_CYC=1, ROWS=2, SCROLL_TICKS=1. Required response:
  - row_sel alternates 00,01,00,10.
  - tick_scroll on every tick_row with run=1.
  - row_sel is never multi-hot across 100 cycles.
